// File: rtl/debounced_event_inputs_if.sv
// Event read port of debounced_event_inputs: first-word-fall-through head entry with ready/valid.
interface debounced_event_inputs_if #(
    parameter int CHW = 3
);
    logic           ev_valid_o;
    logic           ev_ready_i;
    logic [CHW-1:0] ev_chan_o;
    logic           ev_rise_o;
    logic           ev_repeat_o;

    modport master (
        output ev_valid_o, ev_chan_o, ev_rise_o, ev_repeat_o,
        input  ev_ready_i
    );

    modport slave (
        input  ev_valid_o, ev_chan_o, ev_rise_o, ev_repeat_o,
        output ev_ready_i
    );
endinterface

// File: rtl/debounced_event_inputs.sv
// Synchronise and debounce N_CH raw lines, emit press/release pulses and queue channel-tagged events.
// Optional auto-repeat of held channels: define DEBOUNCED_EVENT_AUTOREPEAT_EN.
module debounced_event_inputs #(
    parameter int N_CH            = 8,
    parameter int DEBOUNCE_CYCLES = 5_000_000,
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          raw_i,
    output logic [N_CH-1:0]          level_o,
    output logic [N_CH-1:0]          press_o,
    output logic [N_CH-1:0]          release_o,
    debounced_event_inputs_if.master ev,
    output logic                     overflow_o,
    input  logic                     clr_overflow_i
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0] meta, sync;
    logic [CW-1:0]   cnt [N_CH];
    logic [N_CH-1:0] flip, rise_ev, fall_ev, rep_fire;
    logic [N_CH-1:0] pend_rise, pend_fall, grant_rise, grant_fall;
    logic            lose, push, pop, full, can_accept, found;
    logic [CHW-1:0]  push_chan;
    logic            push_rise, push_rep;
    logic [AW:0]     wptr, rptr;
    logic [CHW-1:0]  mem_chan [FIFO_DEPTH];
    logic            mem_rise [FIFO_DEPTH];
    logic            mem_rep  [FIFO_DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw_i;
            sync <= meta;
        end
    end

    always_comb begin
        flip = '0;
        for (int unsigned c = 0; c < N_CH; c++)
            flip[c] = (sync[c] != level_o[c]) && (cnt[c] == CNT_LAST);
        rise_ev = flip & ~level_o;
        fall_ev = flip & level_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned c = 0; c < N_CH; c++) cnt[c] <= '0;
            level_o   <= '0;
            press_o   <= '0;
            release_o <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if ((sync[c] == level_o[c]) || flip[c]) cnt[c] <= '0;
                else                                    cnt[c] <= cnt[c] + 1'b1;
            end
            level_o   <= level_o ^ flip;
            press_o   <= rise_ev;
            release_o <= fall_ev;
        end
    end

    // Fixed priority: lowest channel first, rise before fall within a channel.
    always_comb begin
        grant_rise = '0;
        grant_fall = '0;
        push_chan  = '0;
        push_rise  = 1'b0;
        found      = 1'b0;
        if (can_accept) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (!found && pend_rise[c]) begin
                    found         = 1'b1;
                    grant_rise[c] = 1'b1;
                    push_chan     = CHW'(c);
                    push_rise     = 1'b1;
                end else if (!found && pend_fall[c]) begin
                    found         = 1'b1;
                    grant_fall[c] = 1'b1;
                    push_chan     = CHW'(c);
                end
            end
        end
        push = found;
    end

    // A flag being drained this cycle can take a new event without loss.
    assign lose = |((rise_ev & pend_rise & ~grant_rise) | (fall_ev & pend_fall & ~grant_fall));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_rise  <= '0;
            pend_fall  <= '0;
            overflow_o <= 1'b0;
        end else begin
            pend_rise <= (pend_rise & ~grant_rise) | rise_ev | rep_fire;
            pend_fall <= (pend_fall & ~grant_fall) | fall_ev;
            if (lose)                overflow_o <= 1'b1;
            else if (clr_overflow_i) overflow_o <= 1'b0;
        end
    end

`ifdef DEBOUNCED_EVENT_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]   rcnt [N_CH];
    logic [N_CH-1:0] rfirst, pend_rep, rep_free;

    always_comb begin
        rep_fire = '0;
        for (int unsigned c = 0; c < N_CH; c++)
            rep_fire[c] = level_o[c] && !fall_ev[c] &&
                          (rcnt[c] == (rfirst[c] ? FIRST_LAST : NEXT_LAST));
        rep_free = ~pend_rise | grant_rise;
        push_rep = |(grant_rise & pend_rep);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned c = 0; c < N_CH; c++) rcnt[c] <= '0;
            rfirst   <= '1;
            pend_rep <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (!level_o[c] || fall_ev[c]) begin
                    rcnt[c]   <= '0;
                    rfirst[c] <= 1'b1;
                end else if (rep_fire[c]) begin
                    rcnt[c]   <= '0;
                    rfirst[c] <= 1'b0;
                end else begin
                    rcnt[c]   <= rcnt[c] + 1'b1;
                end
            end
            // A coalesced or dropped event leaves the pending entry's tag untouched.
            pend_rep <= (pend_rep & ~rep_free) | (rep_free & rep_fire);
        end
    end

    assign ev.ev_repeat_o = ev.ev_valid_o ? mem_rep[rptr[AW-1:0]] : 1'b0;
`else
    assign rep_fire       = '0;
    assign push_rep       = 1'b0;
    assign ev.ev_repeat_o = 1'b0;
`endif

    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = ev.ev_valid_o && ev.ev_ready_i;
    assign can_accept = !full || pop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_chan[wptr[AW-1:0]] <= push_chan;
            mem_rise[wptr[AW-1:0]] <= push_rise;
            mem_rep[wptr[AW-1:0]]  <= push_rep;
        end
    end

    assign ev.ev_valid_o = (wptr != rptr);
    assign ev.ev_chan_o  = ev.ev_valid_o ? mem_chan[rptr[AW-1:0]] : '0;
    assign ev.ev_rise_o  = ev.ev_valid_o ? mem_rise[rptr[AW-1:0]] : 1'b0;
endmodule

// File: doc/debounced_event_inputs.md
# debounced_event_inputs

Parametrised debounced input block for the debug I/O path. It synchronises and debounces `N_CH` raw button/switch lines and presents the stable levels and one-cycle press/release pulses. It also queues press/release events, tagged with the channel number, in a ready/valid FIFO for a downstream register or bus slave. It generalises the fixed 4-button/4-switch debug input with per-channel edge events, buffering, overflow reporting and optional auto-repeat.

## Interface
- `N_CH`, default 8: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, default 5_000_000: cycles a synchronised input must differ from `level_o` before `level_o` flips; minimum 1.
- `FIFO_DEPTH`, default 8: event FIFO entries; power of 2, minimum 2.
- `REPEAT_DELAY`, default 50_000_000: cycles from press to first auto-repeat; used only with the macro.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeats; used only with the macro.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: asynchronous, active-low reset.
- `raw_i` input N_CH: asynchronous raw inputs.
- `level_o` output N_CH: debounced levels.
- `press_o` output N_CH: one-cycle pulse on each `level_o` rise.
- `release_o` output N_CH: one-cycle pulse on each `level_o` fall.
- `ev_valid_o` output 1: FIFO not empty.
- `ev_ready_i` input 1: consumer accepts the head entry.
- `ev_chan_o` output max(1,$clog2(N_CH)): channel index of the head entry.
- `ev_rise_o` output 1: head entry direction; 1 = press, 0 = release.
- `ev_repeat_o` output 1: head entry is an auto-repeat.
- `overflow_o` output 1: sticky flag, set when an event is lost.
- `clr_overflow_i` input 1: synchronous clear of `overflow_o`.

## Operation
- **Synchroniser:** each channel passes through a 2-flop synchroniser, giving `sync[c]`.
- **Debounce counter, per channel:**
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - If `sync[c] == level_o[c]`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and `sync[c]` still differs, `level_o[c]` flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches `level_o`.
- **Edge pulses:** `press_o[c]` and `release_o[c]` are registered and high for exactly the first cycle of the new level.
- **Pending flags:** each channel has `pend_rise[c]` and `pend_fall[c]`.
  - A `level_o` flip sets the matching flag on the same edge.
  - If that flag is already set, `overflow_o` is set and the new event is dropped.
- **Arbiter:**
  - Each cycle that the FIFO can accept, exactly one pending flag is written into the FIFO and cleared.
  - Priority: lowest channel index first.
  - Within one channel, rise before fall.
  - The FIFO can accept when it is not full, or when it is full and being popped in the same cycle.
- **FIFO:**
  - First-word-fall-through; `ev_*` outputs show the head entry.
  - An entry is popped when `ev_valid_o && ev_ready_i`.
  - `ev_*` outputs are held stable while `ev_valid_o && !ev_ready_i`.
  - Pointers wrap modulo FIFO_DEPTH.
  - A full FIFO never overwrites; events back up in the pending flags.
- **Overflow clear:** `clr_overflow_i` clears `overflow_o`. If a set and a clear occur in the same cycle, set wins.
- **Reset (asserted at any time):**
  - Synchronisers, counters, pending flags and FIFO are cleared, and in-flight events are discarded.
  - `level_o`, `press_o`, `release_o`, `ev_valid_o`, `overflow_o`, `ev_chan_o`, `ev_rise_o` and `ev_repeat_o` all read 0, regardless of `raw_i`.

## Timing
- Latency from a `raw_i` change to `level_o`: 2 synchroniser cycles plus DEBOUNCE_CYCLES, with `raw_i` held stable throughout.
- `press_o`/`release_o` assert in the same cycle as the `level_o` change.
- `ev_valid_o` rises 1 cycle after `level_o` changes, when the FIFO is empty and no higher-priority flag is pending.
- Throughput: 1 FIFO write per cycle and 1 pop per cycle; simultaneous push and pop is allowed.
- Simultaneous edges on k channels enter the FIFO on k consecutive cycles, in index order.

## Configuration
- **`DEBOUNCED_EVENT_AUTOREPEAT_EN` defined:**
  - Each channel has a repeat counter that runs while `level_o[c]` is 1.
  - REPEAT_DELAY cycles after the press, and then every REPEAT_PERIOD cycles, `pend_rise[c]` is set with a repeat tag. The queued entry has `ev_rise_o`=1 and `ev_repeat_o`=1.
  - A repeat that finds `pend_rise[c]` already set is coalesced silently and does not set `overflow_o`.
  - The counter clears on release and on reset.
- **Macro not defined:** no repeat logic; `ev_repeat_o` is tied to 0.

## Test plan
Parameters for all scenarios: N_CH=4, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
- Pulse `raw_i[1]` high for 3 cycles -> `level_o` stays 0 and no event is queued.
- Hold `raw_i[1]` high -> `level_o[1]` rises 6 cycles after the synchroniser input changes, with a single `press_o[1]` pulse. One cycle later `ev_valid_o`=1, `ev_chan_o`=1, `ev_rise_o`=1.
- Raise `raw_i[3:0]` together with `ev_ready_i`=1 -> events for channels 0,1,2,3 (all rise) on 4 consecutive cycles.
- With `ev_ready_i`=0, toggle channel 0 stably: 4 presses/releases fill the FIFO, 2 more fill the pending flags, and a 7th edge sets `overflow_o`. Raising `clr_overflow_i` then clears it.
- Assert reset with 3 entries queued and `level_o[2]`=1 -> all outputs read 0 immediately and stay 0 until inputs re-debounce.
- With the macro defined, REPEAT_DELAY=10 and REPEAT_PERIOD=5, hold channel 2 -> a press event, then repeat events (`ev_repeat_o`=1) 10 cycles after `level_o` rises and every 5 cycles after that. Releasing the channel stops the repeats and queues a release event.
